// File: rtl/wb_stage.sv
// Write-back stage: zero-latency ALU write-back plus a req/gnt/rvalid data-bus
// sequencer for loads and stores, with an optional response timeout.
module wb_stage #(
    parameter int XLEN    = 64,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  raddr_i,
    input  logic [XLEN-1:0]  result_i,
    input  logic [REG_W-1:0] rd_idx_i,
    input  logic             wb_i,
    input  logic             rmem_i,
    input  logic             wmem_i,
    output logic             hold_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [XLEN-1:0]  bus_addr_o,
    output logic [XLEN-1:0]  bus_wdata_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [XLEN-1:0]  bus_rdata_i,
    output logic             rf_we_o,
    output logic [REG_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]  rf_wdata_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mop;
    logic             rd_ok;
    logic             timeout_hit;

    assign mop   = rmem_i | wmem_i;
    assign rd_ok = wb_i && (rd_idx_i != '0);
    // A zero TIMEOUT disables the abort path; the counter then just wraps harmlessly.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT)) && !bus_rvalid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (mop) state <= REQ;
                REQ: begin
                    if (bus_gnt_i) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i || timeout_hit) state <= IDLE;
                    else                             cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded combinationally so hold_o can release in the completion cycle.
    always_comb begin
        hold_o      = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        rf_we_o     = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        err_o       = 1'b0;
        if (!rst) begin
            rf_waddr_o = rd_idx_i;
            case (state)
                IDLE: begin
                    if (mop) begin
                        hold_o = 1'b1;
                    end else begin
                        rf_we_o    = rd_ok;
                        rf_wdata_o = result_i;
                    end
                end
                REQ: begin
                    hold_o     = 1'b1;
                    bus_req_o  = 1'b1;
                    bus_we_o   = !rmem_i;
                    bus_addr_o = raddr_i;
                    if (!rmem_i) bus_wdata_o = result_i;
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        if (rmem_i) begin
                            rf_we_o    = rd_ok;
                            rf_wdata_o = bus_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        err_o = 1'b1;
                    end else begin
                        hold_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
